// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver for a bank of 7-segment digits.
// The digits share one segment bus {DP,G,F,E,D,C,B,A} and each has its own anode enable.
// Inputs are captured into shadow registers once per frame, on the dead cycle of slot 0.
// Each digit slot starts with one dead cycle that suppresses ghosting between digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_hex_in,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_blank_in,
  output logic [7:0]              o_seg_out,
  output logic [NUM_DIGITS-1:0]   o_an_out,
  output logic                    o_frame_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IdxMax   = IW'(NUM_DIGITS - 1);
  // XOR masks that convert the active-high form into pin polarity.
  localparam logic [7:0] SegOff = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AnOff = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_hex;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_tick;

  logic                  w_load;
  logic                  w_dead;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_blank;
  logic                  w_auto;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [7:0]            w_seg_hi;

  // Active-high glyphs in {G,F,E,D,C,B,A} order.
  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    return g;
  endfunction

  assign w_load = i_en && (r_presc == '0) && (r_idx == '0);
  assign w_dead = !i_en || (r_presc == '0);

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero mask: digit i>0 goes dark when it and every more-significant digit are 0 or blanked.
  always_comb begin
    logic v_run;
    w_lz  = '0;
    v_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i > 0) begin
        w_lz[i] = v_run && (r_sh_hex[4*i +: 4] == 4'h0);
      end
      v_run = v_run && ((r_sh_hex[4*i +: 4] == 4'h0) || r_sh_blank[i]);
    end
  end
`else
  assign w_lz = '0;
`endif

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    w_nib    = '0;
    w_dp     = 1'b0;
    w_blank  = 1'b0;
    w_auto   = 1'b0;
    w_an_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_sh_hex[4*i +: 4];
        w_dp        = r_sh_dp[i];
        w_blank     = r_sh_blank[i];
        w_auto      = w_lz[i];
        w_an_hot[i] = 1'b1;
      end
    end
  end

  // Active-high segment pattern; auto-blanking keeps the DP but an explicit blank drops it.
  always_comb begin
    w_seg_hi = '0;
    if (!w_blank) begin
      w_seg_hi = {w_dp, (w_auto ? 7'b0 : f_glyph(w_nib))};
    end
  end

  // Scan state: prescaler, digit index and per-frame shadow capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_sh_hex   <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
    end else if (!i_en) begin
      r_presc <= '0;
    end else begin
      if (w_load) begin
        r_sh_hex   <= i_hex_in;
        r_sh_dp    <= i_dp_in;
        r_sh_blank <= i_blank_in;
      end
      if (r_presc == PrescMax) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IdxMax) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg  <= SegOff;
      r_an   <= AnOff;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_load;
      if (w_dead) begin
        r_seg <= SegOff;
        r_an  <= AnOff;
      end else begin
        r_seg <= w_seg_hi ^ SegOff;
        r_an  <= w_an_hot ^ AnOff;
      end
    end
  end

  assign o_seg_out    = r_seg;
  assign o_an_out     = r_an;
  assign o_frame_tick = r_tick;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed, multi-digit hex driver for 7-segment display banks that share one segment bus and have per-digit anode enables. It captures a packed vector of hex nibbles, decimal points and blank flags once per frame. It then scans the digits one at a time, with a dead cycle between digits to suppress ghosting. It sits between datapath/display registers and the board's segment and anode pins, replacing one static decoder per digit.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_DIV, 50000: clock cycles per digit slot; legal minimum 2.
- ACTIVE_LOW, 1: 1 = segments and anodes active-low (common-anode); 0 = active-high.

- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable; low blanks the display and freezes the scan.
- hex_in  input  4*NUM_DIGITS  packed nibbles; digit i = hex_in[4i+3:4i]; digit 0 is least significant (rightmost).
- dp_in  input  NUM_DIGITS  decimal point per digit, active-high.
- blank_in  input  NUM_DIGITS  forces digit i fully dark (segments and DP), active-high.
- seg_out  output  8  registered segment bus, ordered {DP,G,F,E,D,C,B,A}.
- an_out  output  NUM_DIGITS  registered anode enables; at most one is active.
- frame_tick  output  1  one-cycle pulse after each shadow-register load.

## Operation
- Prescaler counts 0..CLK_DIV-1. Digit index counts 0..NUM_DIGITS-1 and advances when the prescaler wraps. The index wraps from NUM_DIGITS-1 to 0.
- Each slot lasts CLK_DIV cycles:
  - Cycle 0 of the slot is a dead cycle: all anodes inactive and all segments inactive.
  - Cycles 1..CLK_DIV-1 drive an_out[index] active and seg_out with that digit's glyph.
- Shadow registers hold hex, dp and blank. They load from the inputs on the dead cycle of slot 0 (prescaler=0, index=0, en=1). The display is therefore tear-free within a frame, and input changes mid-frame appear at the next frame.
- Glyphs (active-high form, {G..A}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- DP bit = shadow dp[index].
- Blanked digit: all 8 segment bits inactive, but the anode still follows the scan.
- Polarity: when ACTIVE_LOW=1, both seg_out and an_out are bitwise-inverted from the active-high form.
- en=0: prescaler forced to 0, index held, outputs all inactive. On re-enable, the current slot restarts with its dead cycle.

## Timing
- Reset values: prescaler=0, index=0, shadow hex/dp=0, shadow blank=all ones.
- Outputs during reset: seg_out all inactive (8'hFF when ACTIVE_LOW=1), an_out all inactive, frame_tick=0.
- First enabled cycle after reset is the slot-0 dead cycle. The shadow loads on that edge, and frame_tick=1 the following cycle.
- Outputs are registered: one cycle of latency from internal state to pins.
- Frame period = NUM_DIGITS*CLK_DIV cycles. frame_tick period equals the frame period while en=1.
- rst mid-slot takes priority over en and returns all state to reset values at the next edge.
- With NUM_DIGITS=1, the index stays 0, and every slot is slot 0 and reloads the shadow.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i>0 is blanked when its shadow nibble is 0 and all more-significant digits are 0 or blanked.
  - Digit 0 is never auto-blanked.
  - DP still displays on an auto-blanked digit if dp is set.
- Macro undefined: zeros are displayed on all digits; only blank_in darkens a digit.

## Test plan
- Reset, NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1, hex_in=16'h12AF, en=1 -> frame_tick 2 cycles after reset release. Per slot: an_out=1111 for 1 cycle, then 1110/1101/1011/0111 for 3 cycles each. seg_out = inverted glyphs F, A, 2, 1 with DP=1 (off).
- Change hex_in mid-frame -> display unchanged until the next slot-0 dead cycle, then the new value appears.
- blank_in=4'b0100, dp_in=4'b0001 -> digit 2 segments 8'hFF while its anode is active; digit 0 seg_out[7]=0.
- en low for 10 cycles mid-slot 2 -> outputs inactive; on re-enable, 1 dead cycle, then slot 2 resumes for 3 cycles.
- LEADING_ZERO_BLANK_EN, hex_in=16'h0050 -> digit 3 dark, digit 2 dark, digit 1 shows 5, digit 0 shows 0.
- ACTIVE_LOW=0, hex_in=16'h8888 -> active slots show seg_out=8'h7F and a single-hot an_out; dead cycles show all zeros.
